alu_shift_addr_unit: RTL and testbench
======================================

Name: alu_shift_addr_unit

Overview:
- Execute-stage datapath slice of the ARM-style core: barrel shifter feeding the B input of a 32-bit ALU, plus the address register with its +4 incrementer.
- Sits between the register bank read buses (busA, busB) and the write-back/address buses.
- The decoder drives all control inputs. Shifter and ALU datapath are combinational; ALU result/flags and the address register are registered.

Parameters:
- WIDTH, 32, datapath width. Only 32 is supported.

Ports:
- clk2  in  1  phase-2 clock; all registers update on its rising edge
- rst  in  1  synchronous active-high reset
- bus_a  in  32  ALU operand A
- bus_b  in  32  shifter input (operand 2 before shifting)
- shifter_mode  in  3  0 LSL, 1 LSR, 2 ASR, 3 ROR, 4 RRX, 5-7 pass-through
- shifter_count  in  5  shift/rotate amount
- carry_in_flag  in  1  current CPSR C (used by RRX and as shifter carry when count=0)
- shifter_output  out  32  shifted operand (combinational)
- shifter_carry  out  1  shifter carry-out (combinational)
- alu_invert_a  in  1  use ~A
- alu_invert_b  in  1  use ~shifter_output
- alu_is_logic  in  1  1 = logic op, 0 = add
- alu_logic_idx  in  3  0 AND, 1 ORR, 2 EOR, 3 MOV(B), 4 MVN-style pass ~A', 5-7 = AND
- alu_cin  in  1  adder carry-in
- alu_active  in  1  capture enable for the ALU result/flags registers
- alu_result  out  32  registered ALU result
- alu_n, alu_z, alu_c, alu_v  out  1 each  registered flags
- ale  in  1  address latch enable
- abe  in  1  address bus enable
- alubus  in  32  load value for the address register
- ar  out  32  address output
- incrementerbus  out  32  address register + 4

Behaviour:
Clocking and reset:
- One clock (clk2). Reset is synchronous, active-high.
- Reset clears alu_result, all four flags and the address register to 0.
- Reset wins over any simultaneous enable.

Barrel shifter (combinational, count n):
- LSL: b<<n. Carry = b[32-n], or carry_in_flag when n=0.
- LSR: logical right shift. Carry = b[n-1], or carry_in_flag when n=0.
- ASR: sign-filling right shift. Carry = b[n-1], or carry_in_flag when n=0.
- ROR: rotate right by n. Carry = result[31], or carry_in_flag when n=0.
- RRX: {carry_in_flag, b[31:1]}. Carry = b[0]. Count is ignored.
- Pass-through modes: output = b, carry = carry_in_flag.

ALU datapath (combinational):
- A' = alu_invert_a ? ~bus_a : bus_a.
- B' = alu_invert_b ? ~shifter_output : shifter_output.
- Arithmetic: sum = A' + B' + alu_cin, 33-bit. C = bit 32. V = (A'[31]==B'[31]) && (sum[31]!=A'[31]).
- Logic: result per alu_logic_idx applied to A' and B'. C = shifter_carry. V keeps its previous registered value.
- N = result[31]. Z = (result==0).

ALU registers:
- On a clk2 edge with alu_active=1: alu_result and all flags load the combinational values.
- With alu_active=0: registers hold.
- Latency: 1 cycle from operand/control valid to registered outputs.

Address register:
- On a clk2 edge with ale=1: register <= alubus. Otherwise it holds.
- incrementerbus = register + 4, combinational, wraps modulo 2^32 (0xFFFFFFFC -> 0).
- ar = abe ? register : 0.

Test Plan:
- Immediate ADD: bus_a=5, bus_b=0x0F, mode LSL n=0, arith, cin=0, active=1 -> one cycle later alu_result=0x14, N=Z=C=V=0. Shifter_carry = carry_in_flag.
- SUB: bus_a=5, bus_b=5, invert_b=1, cin=1 -> result=0, Z=1, C=1, N=0, V=0. Also 0x7FFFFFFF+1 -> 0x80000000, N=1, V=1, C=0.
- Shifter sweep on bus_b=0x8000000F:
  - ROR 8 -> 0x0F800000, carry=0.
  - ASR 4 -> 0xF8000000, carry=1.
  - LSL 1 -> 0x0000001E, carry=1.
  - RRX with carry_in_flag=1 -> 0xC0000007, carry=1.
- Logic ops with A=0xFF00FF00, B=0x0F0F0F0F:
  - AND -> 0x0F000F00.
  - ORR -> 0xFF0FFF0F.
  - EOR -> 0xF00FF00F.
  - AND with invert_b -> 0xF000F000 (BIC).
  - Prior V=1 stays 1 through a logic op.
- Hold and reset: alu_active=0 keeps the previous result. rst=1 together with alu_active=1 and ale=1 -> result, flags and address register all 0 next cycle.
- Address register:
  - ale=1, alubus=0x100 -> ar=0x100, incrementerbus=0x104.
  - abe=0 -> ar=0.
  - ale=0 with a new alubus -> ar holds.
  - Load 0xFFFFFFFC -> incrementerbus=0.

Source files
------------

// File: rtl/alu_shift_addr_if.sv
// Operand, control and result signals between the decoder/register bank and the
// execute-stage shifter/ALU/address slice.
interface alu_shift_addr_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] bus_a;
  logic [WIDTH-1:0] bus_b;
  logic [2:0]       shifter_mode;
  logic [4:0]       shifter_count;
  logic             carry_in_flag;
  logic [WIDTH-1:0] shifter_output;
  logic             shifter_carry;
  logic             alu_invert_a;
  logic             alu_invert_b;
  logic             alu_is_logic;
  logic [2:0]       alu_logic_idx;
  logic             alu_cin;
  logic             alu_active;
  logic [WIDTH-1:0] alu_result;
  logic             alu_n;
  logic             alu_z;
  logic             alu_c;
  logic             alu_v;
  logic             ale;
  logic             abe;
  logic [WIDTH-1:0] alubus;
  logic [WIDTH-1:0] ar;
  logic [WIDTH-1:0] incrementerbus;

  modport master (
    output bus_a, bus_b, shifter_mode, shifter_count, carry_in_flag,
    output alu_invert_a, alu_invert_b, alu_is_logic, alu_logic_idx, alu_cin, alu_active,
    output ale, abe, alubus,
    input  shifter_output, shifter_carry, alu_result, alu_n, alu_z, alu_c, alu_v,
    input  ar, incrementerbus
  );

  modport slave (
    input  bus_a, bus_b, shifter_mode, shifter_count, carry_in_flag,
    input  alu_invert_a, alu_invert_b, alu_is_logic, alu_logic_idx, alu_cin, alu_active,
    input  ale, abe, alubus,
    output shifter_output, shifter_carry, alu_result, alu_n, alu_z, alu_c, alu_v,
    output ar, incrementerbus
  );
endinterface

// File: rtl/alu_shift_addr_unit.sv
// Execute-stage slice: barrel shifter into ALU operand B, registered ALU result and
// flags, and the address register with its +4 incrementer. Only WIDTH=32 is supported.
module alu_shift_addr_unit #(
  parameter int WIDTH = 32
) (
  input logic            clk2,
  input logic            rst,
  alu_shift_addr_if.slave io
);

  logic [WIDTH-1:0]        sh_out;
  logic                    sh_c;
  logic [4:0]              sh_n;
  logic [4:0]              lsl_idx;
  logic [4:0]              rsh_idx;
  logic signed [WIDTH-1:0] b_s;
  logic [2*WIDTH-1:0]      ror_dbl;

  logic [WIDTH-1:0] a_op;
  logic [WIDTH-1:0] b_op;
  logic [WIDTH:0]   sum;

  logic [WIDTH-1:0] alu_result_d, alu_result_q;
  logic             alu_n_d, alu_n_q;
  logic             alu_z_d, alu_z_q;
  logic             alu_c_d, alu_c_q;
  logic             alu_v_d, alu_v_q;
  logic [WIDTH-1:0] addr_d, addr_q;

  // Barrel shifter; the carry is the last bit shifted out, with count 0 keeping C.
  always_comb begin
    sh_n    = io.shifter_count;
    lsl_idx = 5'd0 - sh_n;
    rsh_idx = sh_n - 5'd1;
    b_s     = io.bus_b;
    ror_dbl = {io.bus_b, io.bus_b} >> sh_n;
    sh_out  = io.bus_b;
    sh_c    = io.carry_in_flag;
    case (io.shifter_mode)
      3'd0: begin
        sh_out = io.bus_b << sh_n;
        if (sh_n != 5'd0) sh_c = io.bus_b[lsl_idx];
      end
      3'd1: begin
        sh_out = io.bus_b >> sh_n;
        if (sh_n != 5'd0) sh_c = io.bus_b[rsh_idx];
      end
      3'd2: begin
        sh_out = b_s >>> sh_n;
        if (sh_n != 5'd0) sh_c = io.bus_b[rsh_idx];
      end
      3'd3: begin
        sh_out = ror_dbl[WIDTH-1:0];
        if (sh_n != 5'd0) sh_c = ror_dbl[WIDTH-1];
      end
      3'd4: begin
        sh_out = {io.carry_in_flag, io.bus_b[WIDTH-1:1]};
        sh_c   = io.bus_b[0];
      end
      default: ;
    endcase
  end

  // ALU: logic ops take C from the shifter and leave V untouched.
  always_comb begin
    a_op = io.alu_invert_a ? ~io.bus_a : io.bus_a;
    b_op = io.alu_invert_b ? ~sh_out : sh_out;
    sum  = {1'b0, a_op} + {1'b0, b_op} + {{WIDTH{1'b0}}, io.alu_cin};

    alu_result_d = alu_result_q;
    alu_n_d      = alu_n_q;
    alu_z_d      = alu_z_q;
    alu_c_d      = alu_c_q;
    alu_v_d      = alu_v_q;

    if (io.alu_active) begin
      if (io.alu_is_logic) begin
        case (io.alu_logic_idx)
          3'd1:    alu_result_d = a_op | b_op;
          3'd2:    alu_result_d = a_op ^ b_op;
          3'd3:    alu_result_d = b_op;
          3'd4:    alu_result_d = ~a_op;
          default: alu_result_d = a_op & b_op;
        endcase
        alu_c_d = sh_c;
      end else begin
        alu_result_d = sum[WIDTH-1:0];
        alu_c_d      = sum[WIDTH];
        alu_v_d      = (a_op[WIDTH-1] == b_op[WIDTH-1]) &&
                       (sum[WIDTH-1] != a_op[WIDTH-1]);
      end
      alu_n_d = alu_result_d[WIDTH-1];
      alu_z_d = (alu_result_d == '0);
    end

    addr_d = io.ale ? io.alubus : addr_q;
  end

  always_ff @(posedge clk2) begin
    if (rst) begin
      alu_result_q <= '0;
      alu_n_q      <= 1'b0;
      alu_z_q      <= 1'b0;
      alu_c_q      <= 1'b0;
      alu_v_q      <= 1'b0;
      addr_q       <= '0;
    end else begin
      alu_result_q <= alu_result_d;
      alu_n_q      <= alu_n_d;
      alu_z_q      <= alu_z_d;
      alu_c_q      <= alu_c_d;
      alu_v_q      <= alu_v_d;
      addr_q       <= addr_d;
    end
  end

  assign io.shifter_output = sh_out;
  assign io.shifter_carry  = sh_c;
  assign io.alu_result     = alu_result_q;
  assign io.alu_n          = alu_n_q;
  assign io.alu_z          = alu_z_q;
  assign io.alu_c          = alu_c_q;
  assign io.alu_v          = alu_v_q;
  assign io.ar             = io.abe ? addr_q : '0;
  assign io.incrementerbus = addr_q + {{(WIDTH-3){1'b0}}, 3'd4};

endmodule

// File: tb/tb_alu_shift_addr_unit.sv
// Bench for alu_shift_addr_unit: directed cases plus random stimulus against a
// bit-serial / wide-integer reference model.
module tb_alu_shift_addr_unit;

  logic clk2 = 1'b0;
  logic rst  = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic [31:0] m_res  = '0;
  logic        m_n    = 1'b0;
  logic        m_z    = 1'b0;
  logic        m_c    = 1'b0;
  logic        m_v    = 1'b0;
  logic [31:0] m_addr = '0;

  alu_shift_addr_if #(.WIDTH(32)) u_if ();

  alu_shift_addr_unit #(.WIDTH(32)) dut (
    .clk2 (clk2),
    .rst  (rst),
    .io   (u_if)
  );

  always #5 clk2 = ~clk2;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Shift one bit at a time; carry is the last bit that fell off.
  function automatic void ref_shift(input logic [31:0] b, input logic [2:0] mode,
                                    input logic [4:0] cnt, input logic cf,
                                    output logic [31:0] o, output logic co);
    o  = b;
    co = cf;
    case (mode)
      3'd0: for (int i = 0; i < int'(cnt); i++) begin co = o[31]; o = o * 2; end
      3'd1: for (int i = 0; i < int'(cnt); i++) begin co = o[0]; o = o / 2; end
      3'd2: for (int i = 0; i < int'(cnt); i++) begin
              co = o[0];
              o  = (o / 2) | (o & 32'h8000_0000);
            end
      3'd3: begin
              for (int i = 0; i < int'(cnt); i++) o = {o[0], o[31:1]};
              if (cnt != 5'd0) co = o[31];
            end
      3'd4: begin co = b[0]; o = {cf, b[31:1]}; end
      default: ;
    endcase
  endfunction

  function automatic void ref_alu(input logic [31:0] a, input logic [31:0] b,
                                  input logic ia, input logic ib, input logic il,
                                  input logic [2:0] idx, input logic cin,
                                  input logic shc, input logic vprev,
                                  output logic [31:0] r, output logic fn, output logic fz,
                                  output logic fc, output logic fv);
    logic [31:0] ap, bp;
    logic [63:0] s;
    longint      ss;
    ap = ia ? ~a : a;
    bp = ib ? ~b : b;
    if (il) begin
      case (idx)
        3'd1:    r = ap | bp;
        3'd2:    r = ap ^ bp;
        3'd3:    r = bp;
        3'd4:    r = ~ap;
        default: r = ap & bp;
      endcase
      fc = shc;
      fv = vprev;
    end else begin
      s  = {32'd0, ap} + {32'd0, bp} + {63'd0, cin};
      r  = s[31:0];
      fc = s[32];
      ss = longint'($signed(ap)) + longint'($signed(bp)) + longint'(cin);
      fv = (ss > SMAX) || (ss < SMIN);
    end
    fn = r[31];
    fz = (r == 32'd0);
  endfunction

  // Inputs are already applied at a negedge; check combinational outputs, then
  // advance the model across the next clk2 edge and check the registers.
  task automatic cycle();
    logic [31:0] es, er;
    logic        ec, en, ez, ecc, ev;
    #1;
    ref_shift(u_if.bus_b, u_if.shifter_mode, u_if.shifter_count, u_if.carry_in_flag, es, ec);
    chk("shifter_output", u_if.shifter_output, es);
    chk("shifter_carry", {31'd0, u_if.shifter_carry}, {31'd0, ec});
    chk("incrementerbus", u_if.incrementerbus, m_addr + 32'd4);
    chk("ar", u_if.ar, u_if.abe ? m_addr : 32'd0);
    ref_alu(u_if.bus_a, es, u_if.alu_invert_a, u_if.alu_invert_b, u_if.alu_is_logic,
            u_if.alu_logic_idx, u_if.alu_cin, ec, m_v, er, en, ez, ecc, ev);
    if (rst) begin
      m_res = '0; m_n = 0; m_z = 0; m_c = 0; m_v = 0; m_addr = '0;
    end else begin
      if (u_if.alu_active) begin
        m_res = er; m_n = en; m_z = ez; m_c = ecc; m_v = ev;
      end
      if (u_if.ale) m_addr = u_if.alubus;
    end
    @(posedge clk2);
    @(negedge clk2);
    chk("alu_result", u_if.alu_result, m_res);
    chk("flags_nzcv", {28'd0, u_if.alu_n, u_if.alu_z, u_if.alu_c, u_if.alu_v},
        {28'd0, m_n, m_z, m_c, m_v});
  endtask

  task automatic drv(input logic [31:0] a, input logic [31:0] b, input logic [2:0] mode,
                     input logic [4:0] cnt, input logic cf, input logic ia, input logic ib,
                     input logic il, input logic [2:0] idx, input logic cin, input logic act);
    u_if.bus_a         = a;
    u_if.bus_b         = b;
    u_if.shifter_mode  = mode;
    u_if.shifter_count = cnt;
    u_if.carry_in_flag = cf;
    u_if.alu_invert_a  = ia;
    u_if.alu_invert_b  = ib;
    u_if.alu_is_logic  = il;
    u_if.alu_logic_idx = idx;
    u_if.alu_cin       = cin;
    u_if.alu_active    = act;
    cycle();
  endtask

  initial begin
    u_if.ale    = 1'b0;
    u_if.abe    = 1'b1;
    u_if.alubus = '0;
    u_if.bus_a = '0; u_if.bus_b = '0; u_if.shifter_mode = '0; u_if.shifter_count = '0;
    u_if.carry_in_flag = 0; u_if.alu_invert_a = 0; u_if.alu_invert_b = 0;
    u_if.alu_is_logic = 0; u_if.alu_logic_idx = '0; u_if.alu_cin = 0; u_if.alu_active = 0;
    repeat (2) @(posedge clk2);
    @(negedge clk2);
    cycle();
    chk("reset_result", u_if.alu_result, 32'd0);
    chk("reset_ar", u_if.ar, 32'd0);
    rst = 1'b0;

    // ADD immediate, then SUB to zero, then signed overflow
    drv(32'd5, 32'h0F, 3'd0, 5'd0, 1'b1, 0, 0, 0, 3'd0, 0, 1);
    chk("add_result", u_if.alu_result, 32'h14);
    chk("add_flags", {28'd0, u_if.alu_n, u_if.alu_z, u_if.alu_c, u_if.alu_v}, 32'h0);
    chk("add_shc", {31'd0, u_if.shifter_carry}, 32'd1);
    drv(32'd5, 32'd5, 3'd0, 5'd0, 1'b0, 0, 1, 0, 3'd0, 1, 1);
    chk("sub_flags", {28'd0, u_if.alu_n, u_if.alu_z, u_if.alu_c, u_if.alu_v}, 32'h6);
    drv(32'h7FFF_FFFF, 32'd1, 3'd0, 5'd0, 1'b0, 0, 0, 0, 3'd0, 0, 1);
    chk("ovf_result", u_if.alu_result, 32'h8000_0000);
    chk("ovf_flags", {28'd0, u_if.alu_n, u_if.alu_z, u_if.alu_c, u_if.alu_v}, 32'h9);

    // logic ops, V from the overflow must survive
    drv(32'hFF00_FF00, 32'h0F0F_0F0F, 3'd5, 5'd0, 1'b0, 0, 0, 1, 3'd0, 0, 1);
    chk("and_result", u_if.alu_result, 32'h0F00_0F00);
    chk("and_v_hold", {31'd0, u_if.alu_v}, 32'd1);
    drv(32'hFF00_FF00, 32'h0F0F_0F0F, 3'd5, 5'd0, 1'b0, 0, 0, 1, 3'd1, 0, 1);
    chk("orr_result", u_if.alu_result, 32'hFF0F_FF0F);
    drv(32'hFF00_FF00, 32'h0F0F_0F0F, 3'd5, 5'd0, 1'b0, 0, 0, 1, 3'd2, 0, 1);
    chk("eor_result", u_if.alu_result, 32'hF00F_F00F);
    drv(32'hFF00_FF00, 32'h0F0F_0F0F, 3'd5, 5'd0, 1'b0, 0, 1, 1, 3'd0, 0, 1);
    chk("bic_result", u_if.alu_result, 32'hF000_F000);

    // shifter sweep on 0x8000000F
    drv(32'd0, 32'h8000_000F, 3'd3, 5'd8, 1'b1, 0, 0, 1, 3'd3, 0, 1);
    chk("ror8", u_if.shifter_output, 32'h0F80_0000);
    chk("ror8_c", {31'd0, u_if.shifter_carry}, 32'd0);
    drv(32'd0, 32'h8000_000F, 3'd2, 5'd4, 1'b0, 0, 0, 1, 3'd3, 0, 1);
    chk("asr4", u_if.shifter_output, 32'hF800_0000);
    chk("asr4_c", {31'd0, u_if.shifter_carry}, 32'd1);
    drv(32'd0, 32'h8000_000F, 3'd0, 5'd1, 1'b0, 0, 0, 1, 3'd3, 0, 1);
    chk("lsl1", u_if.shifter_output, 32'h0000_001E);
    chk("lsl1_c", {31'd0, u_if.shifter_carry}, 32'd1);
    drv(32'd0, 32'h8000_000F, 3'd4, 5'd9, 1'b1, 0, 0, 1, 3'd3, 0, 1);
    chk("rrx", u_if.shifter_output, 32'hC000_0007);
    chk("rrx_c", {31'd0, u_if.shifter_carry}, 32'd1);

    // hold with alu_active low
    drv(32'h1234_5678, 32'h1, 3'd0, 5'd0, 1'b0, 0, 0, 0, 3'd0, 0, 0);
    chk("hold_result", u_if.alu_result, 32'hC000_0007);

    // address register
    u_if.ale = 1'b1; u_if.alubus = 32'h100;
    cycle();
    chk("addr_load", u_if.ar, 32'h100);
    chk("addr_incr", u_if.incrementerbus, 32'h104);
    u_if.ale = 1'b0; u_if.alubus = 32'hDEAD_BEE0; u_if.abe = 1'b0;
    cycle();
    chk("addr_abe0", u_if.ar, 32'd0);
    u_if.abe = 1'b1;
    cycle();
    chk("addr_hold", u_if.ar, 32'h100);
    u_if.ale = 1'b1; u_if.alubus = 32'hFFFF_FFFC;
    cycle();
    chk("addr_wrap", u_if.incrementerbus, 32'd0);

    // reset beats simultaneous enables
    rst = 1'b1; u_if.alubus = 32'h55AA_0000;
    drv(32'd7, 32'd9, 3'd0, 5'd0, 1'b1, 0, 0, 0, 3'd0, 1, 1);
    chk("rst_result", u_if.alu_result, 32'd0);
    chk("rst_flags", {28'd0, u_if.alu_n, u_if.alu_z, u_if.alu_c, u_if.alu_v}, 32'd0);
    chk("rst_ar", u_if.ar, 32'd0);
    rst = 1'b0;

    // random sweep
    for (int i = 0; i < 400; i++) begin
      rst                = ($urandom_range(0, 49) == 0);
      u_if.bus_a         = $urandom;
      u_if.bus_b         = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      u_if.shifter_mode  = 3'($urandom_range(0, 7));
      u_if.shifter_count = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      u_if.carry_in_flag = 1'($urandom);
      u_if.alu_invert_a  = 1'($urandom);
      u_if.alu_invert_b  = 1'($urandom);
      u_if.alu_is_logic  = 1'($urandom);
      u_if.alu_logic_idx = 3'($urandom);
      u_if.alu_cin       = 1'($urandom);
      u_if.alu_active    = ($urandom_range(0, 3) != 0);
      u_if.ale           = 1'($urandom);
      u_if.abe           = 1'($urandom);
      u_if.alubus        = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom;
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
